// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: the two requester ports (CPU load/store unit and
// loader/debug DMA), the single-port data memory bus, and the busy flag.
// The arbiter connects through the slave modport. The requesters and the
// memory connect through the master modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    logic              busy;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output mem_address, mem_write_data, mem_write, mem_read,
        input  mem_read_data,
        output busy
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  mem_address, mem_write_data, mem_write, mem_read,
        output mem_read_data,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer for the single-port data
// memory. It grants one of two requesters, runs exactly one memory access,
// waits READ_LAT extra cycles on reads, and returns a one-cycle response.
// Optional macro DMEM_ALIGN_CHECK_EN: a misaligned request (addr[1:0] != 0)
// skips the memory access and gets an error response with zero read data.
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave dmem_io
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

    localparam logic [2:0] LAT = 3'(READ_LAT);

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];
`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0]        err_q, err_d;
`endif

    // On a tie the port that was not granted last time wins. Otherwise the only valid port wins.
    logic              any_valid;
    logic              win_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_valid = dmem_io.req0_valid | dmem_io.req1_valid;
    assign win_id    = (dmem_io.req0_valid & dmem_io.req1_valid) ? ~last_gnt_q
                                                                 : dmem_io.req1_valid;
    assign sel_we    = win_id ? dmem_io.req1_we    : dmem_io.req0_we;
    assign sel_addr  = win_id ? dmem_io.req1_addr  : dmem_io.req0_addr;
    assign sel_wdata = win_id ? dmem_io.req1_wdata : dmem_io.req0_wdata;

    // Next-state logic: grant, access, latency wait and response sequencing
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_cnt_d  = lat_cnt_q;
        rdata_d    = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    gnt_d      = win_id;
                    last_gnt_d = win_id;
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    state_d    = S_ACCESS;
`ifdef DMEM_ALIGN_CHECK_EN
                    if (sel_addr[1:0] != 2'b00) begin
                        rdata_d[win_id] = '0;
                        err_d[win_id]   = 1'b1;
                        state_d         = S_RESP;
                    end
`endif
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else if (LAT == 3'd0) begin
                    rdata_d[gnt_q] = dmem_io.mem_read_data;
                    state_d        = S_RESP;
                end else begin
                    lat_cnt_d = LAT;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    rdata_d[gnt_q] = dmem_io.mem_read_data;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef DMEM_ALIGN_CHECK_EN
        // A response that comes through the memory path is always error-free.
        if ((state_q == S_ACCESS || state_q == S_WAIT) && state_d == S_RESP) begin
            err_d[gnt_q] = 1'b0;
        end
`endif
    end

    // State and request/response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_cnt_q  <= 3'd0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q      <= 2'b00;
`endif
        end else begin
            // NOTE: use non-blocking assignments for state so that every register samples pre-edge values.
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_cnt_q  <= lat_cnt_d;
            rdata_q    <= rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // The strobes decode straight from the state register, so an async reset drops them at once.
    assign dmem_io.mem_write      = (state_q == S_ACCESS) & we_q;
    assign dmem_io.mem_read       = ((state_q == S_ACCESS) | (state_q == S_WAIT)) & ~we_q;
    assign dmem_io.mem_address    = addr_q;
    assign dmem_io.mem_write_data = wdata_q;

    assign dmem_io.req0_ready = (state_q == S_IDLE) & any_valid & ~win_id;
    assign dmem_io.req1_ready = (state_q == S_IDLE) & any_valid &  win_id;
    assign dmem_io.rsp0_valid = (state_q == S_RESP) & ~gnt_q;
    assign dmem_io.rsp1_valid = (state_q == S_RESP) &  gnt_q;
    assign dmem_io.rsp0_rdata = rdata_q[0];
    assign dmem_io.rsp1_rdata = rdata_q[1];
`ifdef DMEM_ALIGN_CHECK_EN
    assign dmem_io.rsp0_err   = err_q[0];
    assign dmem_io.rsp1_err   = err_q[1];
`else
    assign dmem_io.rsp0_err   = 1'b0;
    assign dmem_io.rsp1_err   = 1'b0;
`endif
    assign dmem_io.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by random traffic. The bench
// holds a memory device with read latency and a transaction-level reference
// model. The model schedules each accepted request by cycle offset from its
// acceptance, and the outputs are compared on every falling edge.
module tb_dmem_arbiter;
    parameter int READ_LAT = 0;
    localparam int RL = READ_LAT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) mif ();

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(RL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dmem_io (mif)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Memory device. Read data is valid only when the read strobe has been high for RL cycles.
    logic [31:0] dev_mem [0:65535];
    logic [31:0] ref_mem [0:65535];
    int rd_age;

    always @(posedge clk) begin
        if (mif.mem_write) dev_mem[mif.mem_address] <= mif.mem_write_data;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_age <= 0;
        else        rd_age <= mif.mem_read ? rd_age + 1 : 0;
    end

    assign mif.mem_read_data = (mif.mem_read && rd_age == RL) ? dev_mem[mif.mem_address]
                                                              : 32'hBAD0_BAD0;

    // Reference model: the transaction in flight and the response state of each port.
    bit          m_active;
    int          m_k;
    int          m_port;
    bit          m_we;
    bit          m_mis;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    int          m_last;
    logic [31:0] m_rdata [2];
    bit          m_err [2];

    task automatic model_reset();
        m_active   = 1'b0;
        m_k        = 0;
        m_last     = 1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_err[0]   = 1'b0;
        m_err[1]   = 1'b0;
    endtask

    task automatic model_step();
        bit e_rdy [2];
        bit e_rsp [2];
        bit e_busy;
        bit e_mw;
        bit e_mr;
        int win;
        int resp_k;
        int strobe_last;
        e_rdy[0] = 0; e_rdy[1] = 0; e_rsp[0] = 0; e_rsp[1] = 0;
        e_busy = 0; e_mw = 0; e_mr = 0;
        if (!m_active) begin
            win = -1;
            if (mif.req0_valid && mif.req1_valid) win = 1 - m_last;
            else if (mif.req0_valid)              win = 0;
            else if (mif.req1_valid)              win = 1;
            if (win >= 0) begin
                e_rdy[win] = 1;
                m_active   = 1;
                m_k        = 0;
                m_port     = win;
                m_last     = win;
                m_we       = (win == 0) ? mif.req0_we    : mif.req1_we;
                m_addr     = (win == 0) ? mif.req0_addr  : mif.req1_addr;
                m_wdata    = (win == 0) ? mif.req0_wdata : mif.req1_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
                m_mis      = (m_addr % 4) != 0;
`else
                m_mis      = 0;
`endif
                if (m_we && !m_mis) ref_mem[m_addr] = m_wdata;
            end
        end else begin
            m_k++;
            resp_k      = m_mis ? 1 : (m_we ? 2 : 2 + RL);
            strobe_last = m_we ? 1 : 1 + RL;
            e_busy      = 1;
            if (!m_mis && m_k <= strobe_last) begin
                e_mw = m_we;
                e_mr = !m_we;
            end
            if (m_k == resp_k) begin
                e_rsp[m_port] = 1;
                if (m_mis) begin
                    m_rdata[m_port] = '0;
                    m_err[m_port]   = 1;
                end else begin
                    if (!m_we) m_rdata[m_port] = ref_mem[m_addr];
                    m_err[m_port] = 0;
                end
                m_active = 0;
            end
        end
        check_bit("req0_ready", mif.req0_ready, e_rdy[0]);
        check_bit("req1_ready", mif.req1_ready, e_rdy[1]);
        check_bit("busy", mif.busy, e_busy);
        check_bit("mem_write", mif.mem_write, e_mw);
        check_bit("mem_read", mif.mem_read, e_mr);
        if (e_mw || e_mr) check("mem_address", 32'(mif.mem_address), 32'(m_addr));
        if (e_mw)         check("mem_write_data", mif.mem_write_data, m_wdata);
        check_bit("rsp0_valid", mif.rsp0_valid, e_rsp[0]);
        check_bit("rsp1_valid", mif.rsp1_valid, e_rsp[1]);
        check("rsp0_rdata", mif.rsp0_rdata, m_rdata[0]);
        check("rsp1_rdata", mif.rsp1_rdata, m_rdata[1]);
        check_bit("rsp0_err", mif.rsp0_err, m_err[0]);
        check_bit("rsp1_err", mif.rsp1_err, m_err[1]);
    endtask

    // Compare process: one model step per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n)      model_reset();
        else if (chk_en) model_step();
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mif.req0_valid = 0; mif.req0_we = 0; mif.req0_addr = '0; mif.req0_wdata = '0;
        mif.req1_valid = 0; mif.req1_we = 0; mif.req1_addr = '0; mif.req1_wdata = '0;
    endtask

    task automatic reset_pulse();
        next_cycle();
        idle_inputs();
        rst_n = 0;
        next_cycle();
        next_cycle();
        rst_n = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants[$];
        bit mw_seen;
        idle_inputs();
        for (int i = 0; i < 65536; i++) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = dev_mem[i];
        end
        dev_mem[12] = 32'hDEAD_BEEF; ref_mem[12] = 32'hDEAD_BEEF;
        dev_mem[1]  = 32'h1234_5678; ref_mem[1]  = 32'h1234_5678;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("reset mem_write", mif.mem_write, 0);
        check_bit("reset mem_read", mif.mem_read, 0);
        check("reset mem_address", 32'(mif.mem_address), 0);
        check("reset mem_write_data", mif.mem_write_data, 0);
        check_bit("reset busy", mif.busy, 0);
        check_bit("reset rsp0_valid", mif.rsp0_valid, 0);
        check("reset rsp0_rdata", mif.rsp0_rdata, 0);
        check("reset rsp1_rdata", mif.rsp1_rdata, 0);
        check_bit("reset req0_ready", mif.req0_ready, 0);
        next_cycle();
        rst_n  = 1;
        chk_en = 1;

        // Port 0 write addr=4 wdata=18
        mif.req0_valid = 1; mif.req0_we = 1; mif.req0_addr = 16'd4; mif.req0_wdata = 32'd18;
        @(negedge clk);
        check_bit("wr accept ready0", mif.req0_ready, 1);
        check_bit("wr accept busy", mif.busy, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check_bit("wr access mem_write", mif.mem_write, 1);
        check("wr access mem_address", 32'(mif.mem_address), 4);
        check("wr access mem_write_data", mif.mem_write_data, 18);
        check_bit("wr access busy", mif.busy, 1);
        next_cycle();
        @(negedge clk);
        check_bit("wr resp mem_write", mif.mem_write, 0);
        check_bit("wr resp rsp0_valid", mif.rsp0_valid, 1);
        check_bit("wr resp busy", mif.busy, 1);
        next_cycle();
        @(negedge clk);
        check_bit("wr done busy", mif.busy, 0);

        // Port 0 read addr=4 returns the value written above
        next_cycle();
        mif.req0_valid = 1; mif.req0_we = 0; mif.req0_addr = 16'd4;
        @(negedge clk);
        check_bit("rd accept ready0", mif.req0_ready, 1);
        next_cycle();
        idle_inputs();
        for (int i = 0; i <= RL; i++) begin
            @(negedge clk);
            check_bit("rd strobe mem_read", mif.mem_read, 1);
            check("rd strobe mem_address", 32'(mif.mem_address), 4);
            next_cycle();
        end
        @(negedge clk);
        check_bit("rd resp mem_read", mif.mem_read, 0);
        check_bit("rd resp rsp0_valid", mif.rsp0_valid, 1);
        check("rd resp rsp0_rdata", mif.rsp0_rdata, 18);
        check_bit("rd resp rsp1_valid", mif.rsp1_valid, 0);

        // Both ports valid continuously from reset: grants alternate starting with port 0
        reset_pulse();
        mif.req0_valid = 1; mif.req0_we = 0; mif.req0_addr = 16'd0;
        mif.req1_valid = 1; mif.req1_we = 0; mif.req1_addr = 16'd8;
        mw_seen = 0;
        for (int c = 0; c < 60 && grants.size() < 4; c++) begin
            @(negedge clk);
            if (mif.req0_ready) grants.push_back(0);
            if (mif.req1_ready) grants.push_back(1);
            if (mif.mem_write)  mw_seen = 1;
            next_cycle();
        end
        idle_inputs();
        check("tie grant count", 32'(grants.size()), 4);
        for (int i = 0; i < grants.size(); i++) check("tie grant order", 32'(grants[i]), 32'(i % 2));
        check_bit("tie mem_write seen", mw_seen, 0);
        repeat (3 + RL) next_cycle();

        // Port 1 read addr=12, then reset during the access/wait phase
        mif.req1_valid = 1; mif.req1_we = 0; mif.req1_addr = 16'd12;
        @(negedge clk);
        check_bit("abort accept ready1", mif.req1_ready, 1);
        next_cycle();
        idle_inputs();
        if (RL > 0) next_cycle();
        @(negedge clk);
        check_bit("abort pre mem_read", mif.mem_read, 1);
        #1 rst_n = 0;
        #1;
        check_bit("abort async mem_read", mif.mem_read, 0);
        check_bit("abort async busy", mif.busy, 0);
        check_bit("abort rsp1_valid", mif.rsp1_valid, 0);
        next_cycle();
        next_cycle();
        rst_n = 1;
        mif.req0_valid = 1; mif.req0_we = 0; mif.req0_addr = 16'd12;
        mif.req1_valid = 1; mif.req1_we = 0; mif.req1_addr = 16'd12;
        @(negedge clk);
        check_bit("post reset tie ready0", mif.req0_ready, 1);
        check_bit("post reset tie ready1", mif.req1_ready, 0);
        next_cycle();
        idle_inputs();
        repeat (3 + RL) next_cycle();

        // Misaligned port 0 read addr=1
        mif.req0_valid = 1; mif.req0_we = 0; mif.req0_addr = 16'd1;
        @(negedge clk);
        check_bit("mis accept ready0", mif.req0_ready, 1);
        next_cycle();
        idle_inputs();
`ifdef DMEM_ALIGN_CHECK_EN
        @(negedge clk);
        check_bit("mis mem_read", mif.mem_read, 0);
        check_bit("mis rsp0_valid", mif.rsp0_valid, 1);
        check_bit("mis rsp0_err", mif.rsp0_err, 1);
        check("mis rsp0_rdata", mif.rsp0_rdata, 0);
`else
        @(negedge clk);
        check_bit("mis mem_read", mif.mem_read, 1);
        check("mis mem_address", 32'(mif.mem_address), 1);
        repeat (1 + RL) next_cycle();
        @(negedge clk);
        check_bit("mis rsp0_valid", mif.rsp0_valid, 1);
        check_bit("mis rsp0_err", mif.rsp0_err, 0);
        check("mis rsp0_rdata", mif.rsp0_rdata, 32'h1234_5678);
`endif
        repeat (3 + RL) next_cycle();

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            mif.req0_valid = ($urandom_range(0, 3) != 0);
            mif.req1_valid = ($urandom_range(0, 3) != 0);
            mif.req0_we    = $urandom_range(0, 1) == 1;
            mif.req1_we    = $urandom_range(0, 1) == 1;
            mif.req0_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15) * 4);
            mif.req1_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15) * 4);
            mif.req0_wdata = $urandom;
            mif.req1_wdata = $urandom;
            next_cycle();
        end
        idle_inputs();
        repeat (10) next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
